// File: rtl/uart_receiver.sv
// UART receiver: 2-flop Rx synchroniser, oversampled start/data/stop FSM, and a
// sticky ready/overrun/frame-error word interface for the downstream consumer.
module uart_receiver #(
  parameter int DATA_BITS  = 16,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk_50m,
  input  logic                 rst_n,
  input  logic                 Rx,
  input  logic                 clken,
  input  logic                 rdy_clr,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 rdy,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 Rx_busy
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int POS_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(DATA_BITS - 1);
  localparam logic [POS_W-1:0] POS_ONE  = POS_W'(1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t               state, state_nxt;
  logic                 rx_meta, rx_s;
  logic [CNT_W-1:0]     sample_cnt, cnt_nxt;
  logic [POS_W-1:0]     bit_pos, pos_nxt;
  logic [DATA_BITS-1:0] shift;
  logic                 bit_take, frame_good, frame_bad;

  // Stage: Rx synchroniser, idles high so reset never looks like a start bit
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= Rx;
      rx_s    <= rx_meta;
    end
  end

  // Stage: frame FSM state and counters
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sample_cnt <= '0;
      bit_pos    <= '0;
    end else begin
      state      <= state_nxt;
      sample_cnt <= cnt_nxt;
      bit_pos    <= pos_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = sample_cnt;
    pos_nxt    = bit_pos;
    bit_take   = 1'b0;
    frame_good = 1'b0;
    frame_bad  = 1'b0;
    if (clken) begin
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state_nxt = START;
            cnt_nxt   = '0;
          end
        end
        START: begin
          cnt_nxt = sample_cnt + CNT_ONE;
          if (sample_cnt == CNT_HALF) begin
            cnt_nxt = '0;
            if (!rx_s) begin
              state_nxt = DATA;
              pos_nxt   = '0;
            end else begin
              state_nxt = IDLE;
            end
          end
        end
        DATA: begin
          cnt_nxt = sample_cnt + CNT_ONE;
          if (sample_cnt == CNT_LAST) begin
            cnt_nxt  = '0;
            bit_take = 1'b1;
            pos_nxt  = bit_pos + POS_ONE;
            if (bit_pos == POS_LAST) state_nxt = STOP;
          end
        end
        STOP: begin
          cnt_nxt = sample_cnt + CNT_ONE;
          if (sample_cnt == CNT_LAST) begin
            cnt_nxt   = '0;
            state_nxt = IDLE;
            if (rx_s) frame_good = 1'b1;
            else      frame_bad  = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Stage: data shift register (payload only, no reset needed)
  always_ff @(posedge clk_50m) begin
    if (bit_take) shift[bit_pos] <= rx_s;
  end

  // Stage: consumer-facing word and sticky flags; a completing good frame beats rdy_clr
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      data_out  <= '0;
      rdy       <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else if (frame_good) begin
      data_out  <= shift;
      rdy       <= 1'b1;
      overrun   <= rdy;
      frame_err <= 1'b0;
    end else begin
      if (frame_bad) frame_err <= 1'b1;
      if (rdy_clr) begin
        rdy     <= 1'b0;
        overrun <= 1'b0;
      end
    end
  end

  assign Rx_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Directed + randomized bench for uart_receiver against a word-level model of
// the consumer interface (data_out/rdy/frame_err/overrun).
module tb_uart_receiver;

  localparam int DB = 16;
  localparam int OS = 16;

  logic          clk_50m = 1'b0;
  logic          rst_n, Rx, clken, rdy_clr;
  logic [DB-1:0] data_out;
  logic          rdy, frame_err, overrun, Rx_busy;

  int total = 0;
  int bad   = 0;
  int clk_div = 4;
  int div_cnt = 0;

  logic [DB-1:0] m_data;
  logic          m_rdy, m_ferr, m_ovr;

  uart_receiver #(.DATA_BITS(DB), .OVERSAMPLE(OS)) dut (
    .clk_50m  (clk_50m),
    .rst_n    (rst_n),
    .Rx       (Rx),
    .clken    (clken),
    .rdy_clr  (rdy_clr),
    .data_out (data_out),
    .rdy      (rdy),
    .frame_err(frame_err),
    .overrun  (overrun),
    .Rx_busy  (Rx_busy)
  );

  always #10 clk_50m = ~clk_50m;

  always @(negedge clk_50m) begin
    div_cnt = (div_cnt + 1) % clk_div;
    clken   = (div_cnt == 0);
  end

  initial begin
    #50_000_000;
    $display("FAIL watchdog: time limit expired before summary");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".data_out"},  32'(data_out),  32'(m_data));
    check({tag, ".rdy"},       32'(rdy),       32'(m_rdy));
    check({tag, ".frame_err"}, 32'(frame_err), 32'(m_ferr));
    check({tag, ".overrun"},   32'(overrun),   32'(m_ovr));
    check({tag, ".Rx_busy"},   32'(Rx_busy),   32'(0));
  endtask

  // Word-level reference: what the consumer should see after each frame
  task automatic model_frame(input logic [DB-1:0] w, input logic stop);
    if (stop) begin
      m_ovr  = m_rdy;
      m_rdy  = 1'b1;
      m_data = w;
      m_ferr = 1'b0;
    end else begin
      m_ferr = 1'b1;
    end
  endtask

  task automatic model_clr();
    m_rdy = 1'b0;
    m_ovr = 1'b0;
  endtask

  task automatic model_reset();
    m_data = '0; m_rdy = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
  endtask

  task automatic idle(input int n);
    Rx = 1'b1;
    repeat (n) @(negedge clk_50m);
  endtask

  task automatic send_frame(input logic [DB-1:0] w, input logic stop);
    logic [DB+1:0] fr;
    fr = {stop, w, 1'b0};
    for (int i = 0; i < DB + 2; i++) begin
      Rx = fr[i];
      repeat (OS * clk_div) @(negedge clk_50m);
    end
    Rx = 1'b1;
  endtask

  task automatic send_model(input logic [DB-1:0] w, input logic stop);
    send_frame(w, stop);
    model_frame(w, stop);
  endtask

  task automatic pulse_clr();
    rdy_clr = 1'b1;
    @(negedge clk_50m);
    rdy_clr = 1'b0;
    model_clr();
  endtask

  initial begin
    logic [DB-1:0] w;
    logic [DB+1:0] fr;
    int pulses, ovr_seen;
    logic [DB-1:0] captured;

    rst_n = 1'b0; Rx = 1'b1; rdy_clr = 1'b0; clken = 1'b0;
    model_reset();
    repeat (3) @(negedge clk_50m);
    check_all("reset");
    rst_n = 1'b1;
    idle(20);

    // Clean frame
    send_model(16'hA5C3, 1'b1);
    idle(OS * clk_div);
    check_all("clean_a5c3");
    pulse_clr();
    check_all("clr_after_a5c3");

    // Short low glitch: busy briefly, then rejected without flags
    Rx = 1'b0;
    repeat (4 * clk_div) @(negedge clk_50m);
    Rx = 1'b1;
    check("glitch.busy_early", 32'(Rx_busy), 32'(1));
    repeat (36) @(negedge clk_50m);
    check_all("glitch_rejected");

    // Bad stop bit after a fresh reset: data_out stays at its reset value
    rst_n = 1'b0; model_reset();
    repeat (2) @(negedge clk_50m);
    rst_n = 1'b1;
    idle(10);
    send_model(16'h1234, 1'b0);
    idle(3 * OS * clk_div);
    check_all("bad_stop_1234");

    // Back-to-back frames without acknowledge
    send_model(16'h0001, 1'b1);
    send_model(16'hFFFF, 1'b1);
    check_all("b2b_overrun");
    idle(5);
    pulse_clr();
    check_all("b2b_cleared");

    // rdy_clr held across the set edge: set must win for exactly that edge
    w = 16'h5A3C ^ 16'($urandom);
    pulses = 0; ovr_seen = 0; captured = '0;
    rdy_clr = 1'b1;
    fork
      send_frame(w, 1'b1);
      begin
        repeat ((DB + 2) * OS * clk_div + 20) begin
          @(negedge clk_50m);
          if (rdy) begin pulses++; captured = data_out; end
          if (overrun) ovr_seen++;
        end
      end
    join
    rdy_clr = 1'b0;
    check("setedge.rdy_pulses", 32'(pulses), 32'(1));
    check("setedge.data", 32'(captured), 32'(w));
    check("setedge.overrun_seen", 32'(ovr_seen), 32'(0));
    m_data = w; m_rdy = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0;
    check_all("setedge_after");

    // Load every flag, then reset asynchronously at data bit 7
    send_model(16'($urandom), 1'b1);
    send_model(16'($urandom), 1'b1);
    send_model(16'($urandom), 1'b0);
    idle(3 * OS * clk_div);
    check_all("preload_flags");
    fr = {1'b1, 16'hC0DE, 1'b0};
    for (int i = 0; i < 8; i++) begin
      Rx = fr[i];
      repeat (OS * clk_div) @(negedge clk_50m);
    end
    Rx = fr[8];
    repeat (OS / 2 * clk_div) @(negedge clk_50m);
    #3 rst_n = 1'b0;
    model_reset();
    #1 check_all("async_reset_mid_frame");
    Rx = 1'b1;
    repeat (3) @(negedge clk_50m);
    rst_n = 1'b1;
    idle(2 * OS * clk_div);
    check_all("after_reset_idle");
    send_model(16'h8001, 1'b1);
    idle(OS * clk_div);
    check_all("post_reset_8001");

    // Randomized loopback at full-rate oversampling
    clk_div = 1;
    idle(10);
    pulse_clr();
    for (int k = 0; k < 128; k++) begin
      idle(int'($urandom_range(0, 40)));
      if ($urandom_range(0, 3) == 0) pulse_clr();
      send_model(16'($urandom), 1'b1);
      check($sformatf("loop%0d.data_out", k), 32'(data_out), 32'(m_data));
      check($sformatf("loop%0d.rdy", k), 32'(rdy), 32'(m_rdy));
      check($sformatf("loop%0d.frame_err", k), 32'(frame_err), 32'(0));
      check($sformatf("loop%0d.overrun", k), 32'(overrun), 32'(m_ovr));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
